word_unpacker: RTL and testbench
================================

// Module: word_unpacker
// PURPOSE
//   Wide-to-narrow serializer: accepts one DATA_DW-bit word per valid/ready handshake and emits
//   it as OUT_DW-bit beats, least-significant beat first, on a second valid/ready interface.
//   Opposite direction of the narrow-to-wide word packer; sits between the core datapath
//   (DATA_DW = 8 under `MCU51, 64 under `WINDOW, else 32) and byte-wide peripherals.
// PARAMETERS
//   DATA_DW  32  input word width; must be an integer multiple of OUT_DW
//   OUT_DW   8   output beat width
//   (derived) N = DATA_DW/OUT_DW beats per word; CNT_W = $clog2(N+1) (min 1)
// PORTS
//   clk      in   1         single clock, all state on rising edge
//   rst_n    in   1         asynchronous, active-low reset
//   s_valid  in   1         input word valid
//   s_ready  out  1         block can take a word this cycle
//   s_data   in   DATA_DW   input word
//   s_len    in   CNT_W     beats to emit from s_data (1..N); 0 or >N treated as N
//   m_valid  out  1         output beat valid
//   m_ready  in   1         downstream accepts beat
//   m_data   out  OUT_DW    output beat
//   m_last   out  1         high on final beat of the current word
//   busy     out  1         word held (state SHIFT)
// BEHAVIOUR
//   Reset (async assert, sync release): state=IDLE, m_valid=0, m_data=0, m_last=0, busy=0,
//     beat counter=0, shift register=0. Reset mid-word discards remaining beats; no partial output.
//   States: IDLE (no word held), SHIFT (word held, m_valid=1).
//   s_ready = (state==IDLE) | (m_valid & m_ready & m_last); combinational from m_ready.
//   Word accept = s_valid & s_ready at a rising edge: load shift reg with s_data, remaining
//     count = clamped s_len, go/stay SHIFT; m_data = s_data[OUT_DW-1:0] valid next cycle.
//   Latency: 1 cycle from word accept edge to first m_valid.
//   Beat transfer = m_valid & m_ready: shift register right by OUT_DW, count -1;
//     m_data takes next beat. m_last = (count==1).
//   Last beat transfer with no new word: -> IDLE, m_valid=0, m_last=0, m_data held (don't care).
//   Last beat transfer with simultaneous word accept: stay SHIFT, load new word; zero bubble,
//     so back-to-back words with m_ready=1 give one beat per cycle sustained.
//   Stall: while m_valid & !m_ready, m_data/m_last stable, no shift; s_ready=0 in SHIFT.
//   s_data/s_len ignored whenever s_ready=0 or s_valid=0.
//   N==1 (DATA_DW==OUT_DW): every beat has m_last=1; block acts as a 1-deep register slice.
//   Beats above s_len are never emitted; unused upper bits of s_data are don't care.
//   busy = (state==SHIFT).
//   Illegal: DATA_DW % OUT_DW != 0 -> elaboration error via generate-time check.
// TESTING
//   1. DATA_DW=32, s_data=32'hA1B2C3D4, s_len=4, m_ready=1 -> m_data A...: D4,C3,B2,A1
//      on 4 consecutive cycles starting 1 cycle after accept; m_last only with A1.
//   2. Two words 32'h11223344 then 32'h55667788 back-to-back, m_ready=1 -> 8 beats
//      44,33,22,11,88,77,66,55 with no gap; s_ready=1 in the cycle of beat 11.
//   3. s_len=2, s_data=32'hDEADBEEF -> beats EF,BE; m_last on BE; s_len=0 -> 4 beats.
//   4. m_ready low for 3 cycles on beat 2 of 32'h01020304 -> m_data=8'h03 and m_valid=1
//      held stable all 3 cycles; s_ready=0; order unchanged after release.
//   5. rst_n pulsed low mid-word after beat 1 -> m_valid=0, busy=0 immediately (async);
//      after release next word 32'hCAFEF00D emits 0D,F0,FE,CA with no stale beats.
//   6. DATA_DW=8 (MCU51), OUT_DW=8, words 8'h5A,8'hA5 -> each 1 beat with m_last=1,
//      one word per cycle when m_ready=1.

Source files
------------

// File: rtl/word_unpacker.sv
// word_unpacker: wide-to-narrow serializer. Takes one DATA_DW-bit word per
// s_valid/s_ready handshake and emits it as OUT_DW-bit beats, LS beat first,
// on an m_valid/m_ready interface. A new word can be taken in the same cycle
// the last beat of the current word transfers, so streaming has no bubbles.
module word_unpacker #(
  parameter  int DATA_DW = 32,
  parameter  int OUT_DW  = 8,
  localparam int N       = DATA_DW / OUT_DW,
  localparam int CNT_W   = ($clog2(N + 1) < 1) ? 1 : $clog2(N + 1)
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               s_valid,
  output logic               s_ready,
  input  logic [DATA_DW-1:0] s_data,
  input  logic [CNT_W-1:0]   s_len,
  output logic               m_valid,
  input  logic               m_ready,
  output logic [OUT_DW-1:0]  m_data,
  output logic               m_last,
  output logic               busy
);

  // A word must split into a whole number of beats.
  if ((DATA_DW % OUT_DW) != 0) begin : g_bad_width
    $error("word_unpacker: DATA_DW must be an integer multiple of OUT_DW");
  end

  typedef enum logic {IDLE = 1'b0, SHIFT = 1'b1} state_e;

  localparam logic [CNT_W-1:0] N_CNT   = CNT_W'(N);
  localparam logic [CNT_W-1:0] ONE_CNT = CNT_W'(1);

  state_e             state_q, state_d;
  logic [DATA_DW-1:0] sreg_q, sreg_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;

  logic             beat_xfer;
  logic             word_acc;
  logic [CNT_W-1:0] len_clamped;

  // Outputs come straight from state; m_data is always the low beat of the
  // shift register, so it stays stable while stalled.
  always_comb begin
    m_valid     = (state_q == SHIFT);
    m_last      = (state_q == SHIFT) && (cnt_q == ONE_CNT);
    m_data      = sreg_q[OUT_DW-1:0];
    busy        = (state_q == SHIFT);
    beat_xfer   = m_valid & m_ready;
    // Accept when empty, or when the final beat leaves this cycle.
    s_ready     = (state_q == IDLE) | (beat_xfer & m_last);
    word_acc    = s_valid & s_ready;
    // Zero or out-of-range lengths mean "emit the whole word".
    len_clamped = ((s_len == '0) || (s_len > N_CNT)) ? N_CNT : s_len;
  end

  // Next-state: shift on beat transfer, load on word accept (load wins so a
  // word arriving with the final beat replaces the drained register).
  always_comb begin
    state_d = state_q;
    sreg_d  = sreg_q;
    cnt_d   = cnt_q;
    if (beat_xfer) begin
      sreg_d = sreg_q >> OUT_DW;
      cnt_d  = cnt_q - ONE_CNT;
      if (m_last) state_d = IDLE;
    end
    if (word_acc) begin
      sreg_d  = s_data;
      cnt_d   = len_clamped;
      state_d = SHIFT;
    end
  end

  // State registers; reset drops any partially emitted word.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      sreg_q  <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      sreg_q  <= sreg_d;
      cnt_q   <= cnt_d;
    end
  end

endmodule

// File: tb/tb_word_unpacker.sv
// Directed bench for word_unpacker: a 32->8 instance (main) and an 8->8
// instance (register-slice case). Inputs change and outputs are sampled
// shortly after the rising edge.
module tb_word_unpacker;

  logic        clk = 1'b0;
  logic        rst_n;

  logic        s_valid, s_ready, m_valid, m_ready, m_last, busy;
  logic [31:0] s_data;
  logic [2:0]  s_len;
  logic [7:0]  m_data;

  logic        b_s_valid, b_s_ready, b_m_valid, b_m_ready, b_m_last, b_busy;
  logic [7:0]  b_s_data, b_m_data;
  logic [0:0]  b_s_len;

  int n_chk  = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  word_unpacker #(.DATA_DW(32), .OUT_DW(8)) u_dut (
    .clk(clk), .rst_n(rst_n),
    .s_valid(s_valid), .s_ready(s_ready), .s_data(s_data), .s_len(s_len),
    .m_valid(m_valid), .m_ready(m_ready), .m_data(m_data), .m_last(m_last),
    .busy(busy)
  );

  word_unpacker #(.DATA_DW(8), .OUT_DW(8)) u_dut8 (
    .clk(clk), .rst_n(rst_n),
    .s_valid(b_s_valid), .s_ready(b_s_ready), .s_data(b_s_data), .s_len(b_s_len),
    .m_valid(b_m_valid), .m_ready(b_m_ready), .m_data(b_m_data), .m_last(b_m_last),
    .busy(b_busy)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Check the current beat, then let it transfer (m_ready assumed high).
  task automatic beat(input string tag, input logic [7:0] d, input logic l);
    #1;
    chk({tag, ".valid"}, 32'(m_valid), 32'd1);
    chk({tag, ".data"},  32'(m_data),  32'(d));
    chk({tag, ".last"},  32'(m_last),  32'(l));
    tick();
  endtask

  task automatic send(input logic [31:0] d, input logic [2:0] len);
    s_valid = 1'b1; s_data = d; s_len = len;
    tick();
    s_valid = 1'b0; s_data = 32'hFFFF_FFFF; s_len = 3'd0;
  endtask

  task automatic idle_chk(input string tag);
    #1;
    chk({tag, ".m_valid"}, 32'(m_valid), 32'd0);
    chk({tag, ".busy"},    32'(busy),    32'd0);
    chk({tag, ".s_ready"}, 32'(s_ready), 32'd1);
  endtask

  initial begin
    rst_n = 1'b0; s_valid = 1'b0; s_data = '0; s_len = '0; m_ready = 1'b1;
    b_s_valid = 1'b0; b_s_data = '0; b_s_len = '0; b_m_ready = 1'b1;
    #12;
    // Reset state
    chk("rst.m_valid", 32'(m_valid), 32'd0);
    chk("rst.m_data",  32'(m_data),  32'd0);
    chk("rst.m_last",  32'(m_last),  32'd0);
    chk("rst.busy",    32'(busy),    32'd0);
    chk("rst.s_ready", 32'(s_ready), 32'd1);
    chk("rst.b_valid", 32'(b_m_valid), 32'd0);
    @(negedge clk); rst_n = 1'b1;
    tick();

    // 1: single full word, first beat one cycle after accept
    s_valid = 1'b1; s_data = 32'hA1B2C3D4; s_len = 3'd4;
    #1;
    chk("t1.s_ready", 32'(s_ready), 32'd1);
    chk("t1.pre_valid", 32'(m_valid), 32'd0);
    tick();
    s_valid = 1'b0;
    beat("t1.b0", 8'hD4, 1'b0);
    beat("t1.b1", 8'hC3, 1'b0);
    beat("t1.b2", 8'hB2, 1'b0);
    #1;
    chk("t1.s_ready_last", 32'(s_ready), 32'd1);
    beat("t1.b3", 8'hA1, 1'b1);
    idle_chk("t1.end");

    // 2: back-to-back words with no bubble
    send(32'h11223344, 3'd4);
    beat("t2.b0", 8'h44, 1'b0);
    #1;
    chk("t2.s_ready_mid", 32'(s_ready), 32'd0);
    beat("t2.b1", 8'h33, 1'b0);
    beat("t2.b2", 8'h22, 1'b0);
    s_valid = 1'b1; s_data = 32'h55667788; s_len = 3'd4;
    #1;
    chk("t2.s_ready_b3", 32'(s_ready), 32'd1);
    beat("t2.b3", 8'h11, 1'b1);
    s_valid = 1'b0;
    beat("t2.b4", 8'h88, 1'b0);
    beat("t2.b5", 8'h77, 1'b0);
    beat("t2.b6", 8'h66, 1'b0);
    beat("t2.b7", 8'h55, 1'b1);
    idle_chk("t2.end");

    // 3: short length, zero length, out-of-range length
    send(32'hDEADBEEF, 3'd2);
    beat("t3a.b0", 8'hEF, 1'b0);
    beat("t3a.b1", 8'hBE, 1'b1);
    idle_chk("t3a.end");
    send(32'hDEADBEEF, 3'd0);
    beat("t3b.b0", 8'hEF, 1'b0);
    beat("t3b.b1", 8'hBE, 1'b0);
    beat("t3b.b2", 8'hAD, 1'b0);
    beat("t3b.b3", 8'hDE, 1'b1);
    idle_chk("t3b.end");
    send(32'h76543210, 3'd7);
    beat("t3c.b0", 8'h10, 1'b0);
    beat("t3c.b1", 8'h32, 1'b0);
    beat("t3c.b2", 8'h54, 1'b0);
    beat("t3c.b3", 8'h76, 1'b1);
    idle_chk("t3c.end");
    send(32'h000000C1, 3'd1);
    beat("t3d.b0", 8'hC1, 1'b1);
    idle_chk("t3d.end");

    // 4: stall on beat 2; a word offered during the stall is ignored
    send(32'h01020304, 3'd4);
    beat("t4.b0", 8'h04, 1'b0);
    m_ready = 1'b0;
    s_valid = 1'b1; s_data = 32'hEEEEEEEE; s_len = 3'd4;
    for (int i = 0; i < 3; i++) begin
      #1;
      chk("t4.stall_valid", 32'(m_valid), 32'd1);
      chk("t4.stall_data",  32'(m_data),  32'h03);
      chk("t4.stall_last",  32'(m_last),  32'd0);
      chk("t4.stall_ready", 32'(s_ready), 32'd0);
      tick();
    end
    s_valid = 1'b0;
    m_ready = 1'b1;
    beat("t4.b1", 8'h03, 1'b0);
    beat("t4.b2", 8'h02, 1'b0);
    beat("t4.b3", 8'h01, 1'b1);
    idle_chk("t4.end");

    // 5: async reset mid-word, then a clean word
    send(32'h0A0B0C0D, 3'd4);
    beat("t5.b0", 8'h0D, 1'b0);
    #2;
    rst_n = 1'b0;
    #1;
    chk("t5.rst_valid", 32'(m_valid), 32'd0);
    chk("t5.rst_busy",  32'(busy),    32'd0);
    chk("t5.rst_data",  32'(m_data),  32'd0);
    @(negedge clk); rst_n = 1'b1;
    tick();
    idle_chk("t5.post");
    send(32'hCAFEF00D, 3'd4);
    beat("t5.b1", 8'h0D, 1'b0);
    beat("t5.b2", 8'hF0, 1'b0);
    beat("t5.b3", 8'hFE, 1'b0);
    beat("t5.b4", 8'hCA, 1'b1);
    idle_chk("t5.end");

    // 6: DATA_DW == OUT_DW, one word per cycle
    b_s_valid = 1'b1; b_s_data = 8'h5A; b_s_len = 1'b1;
    tick();
    b_s_data = 8'hA5; b_s_len = 1'b0;
    #1;
    chk("t6.w0_valid", 32'(b_m_valid), 32'd1);
    chk("t6.w0_data",  32'(b_m_data),  32'h5A);
    chk("t6.w0_last",  32'(b_m_last),  32'd1);
    chk("t6.w0_ready", 32'(b_s_ready), 32'd1);
    tick();
    b_s_valid = 1'b0;
    #1;
    chk("t6.w1_valid", 32'(b_m_valid), 32'd1);
    chk("t6.w1_data",  32'(b_m_data),  32'hA5);
    chk("t6.w1_last",  32'(b_m_last),  32'd1);
    tick();
    #1;
    chk("t6.end_valid", 32'(b_m_valid), 32'd0);
    chk("t6.end_busy",  32'(b_busy),    32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
